falco_mem_arbiter: RTL and testbench

- Shares a single-port data/instruction memory model between three requesters: instruction fetch, load, and store.
- Uses fixed priority with starvation escalation.
- Allows one outstanding transaction at a time, with a bounded response wait and a timeout flag.
- Sits between the Falco core's fetch/LSU request interfaces and the memory model, so fuzzing can exercise contention and back-pressure.

---
 rtl/falco_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_falco_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falco_mem_arbiter.sv
// Falco memory arbiter: shares one memory port between fetch, load and store
// requesters with starvation-aware fixed priority and one outstanding transaction.
module falco_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_req_ready,
  output logic              ld_resp_valid,
  output logic [DATA_W-1:0] ld_resp_data,
  input  logic              st_req_valid,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [DATA_W-1:0] st_req_data,
  output logic              st_req_ready,
  output logic              st_resp_valid,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_ST, OWN_LD, OWN_IF} owner_t;

  localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0][7:0]   starve_q, starve_d;
  logic [9:0]        tmo_q, tmo_d;
  logic              tmo_err_q, tmo_err_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;

  logic [2:0]        req_v, starved, pool, grant;
  logic [DATA_W-1:0] resp_data;
  logic              finish;

  function automatic logic [7:0] starve_next(input logic valid, input logic granted,
                                             input logic [7:0] cnt);
    if (!valid || granted) return '0;
    if (cnt < LIMIT) return cnt + 8'd1;
    return cnt;
  endfunction

  assign req_v   = {if_req_valid, ld_req_valid, st_req_valid};
  assign starved = req_v & {starve_q[2] == LIMIT, starve_q[1] == LIMIT, starve_q[0] == LIMIT};
  // Starved requesters form the candidate pool when present; bit 0 (store) ranks first.
  assign pool    = (starved != 3'b000) ? starved : req_v;

  always_comb begin
    grant = '0;
    if (rst_n && state_q == S_IDLE) begin
      if (pool[0])      grant = 3'b001;
      else if (pool[1]) grant = 3'b010;
      else if (pool[2]) grant = 3'b100;
    end
  end

  assign starve_d[0] = starve_next(req_v[0], grant[0], starve_q[0]);
  assign starve_d[1] = starve_next(req_v[1], grant[1], starve_q[1]);
  assign starve_d[2] = starve_next(req_v[2], grant[2], starve_q[2]);

  // A timeout completes with zero data because mem_resp_valid is low on that edge.
  assign resp_data = mem_resp_valid ? mem_resp_data : '0;
  assign finish    = mem_resp_valid || (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
    if_data_d = if_data_q;
    ld_data_d = ld_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant[0]) begin
          owner_d = OWN_ST;
          addr_d  = st_req_addr;
          wdata_d = st_req_data;
          we_d    = 1'b1;
          state_d = S_ISSUE;
        end else if (grant[1]) begin
          owner_d = OWN_LD;
          addr_d  = ld_req_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          state_d = S_ISSUE;
        end else if (grant[2]) begin
          owner_d = OWN_IF;
          addr_d  = if_req_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (finish) begin
          state_d = S_RESP;
          if (!mem_resp_valid) tmo_err_d = 1'b1;
          if (owner_q == OWN_IF) if_data_d = resp_data;
          if (owner_q == OWN_LD) ld_data_d = resp_data;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_ST;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      starve_q  <= '0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
      if_data_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
      if_data_q <= if_data_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign st_req_ready  = grant[0];
  assign ld_req_ready  = grant[1];
  assign if_req_ready  = grant[2];
  assign st_resp_valid = (state_q == S_RESP) && (owner_q == OWN_ST);
  assign ld_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LD);
  assign if_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign if_resp_data  = if_data_q;
  assign ld_resp_data  = ld_data_q;
  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign timeout_err   = tmo_err_q;

endmodule

// File: tb/tb_falco_mem_arbiter.sv
// Randomised scoreboard bench for falco_mem_arbiter: a requester model predicts
// grants, a memory model predicts responses, and a monitor checks every response.
module tb_falco_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_valid, ld_req_valid, st_req_valid;
  logic [AW-1:0] if_req_addr, ld_req_addr, st_req_addr;
  logic [DW-1:0] st_req_data;
  logic          if_req_ready, ld_req_ready, st_req_ready;
  logic          if_resp_valid, ld_resp_valid, st_resp_valid;
  logic [DW-1:0] if_resp_data, ld_resp_data;
  logic          mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_data;
  logic          timeout_err;

  always #5 clk = ~clk;

  falco_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_ready(st_req_ready), .st_resp_valid(st_resp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .timeout_err(timeout_err)
  );

  typedef struct { int owner; logic [31:0] addr; logic [31:0] wdata; logic we; } grant_t;
  typedef struct { int owner; logic [31:0] data; logic tmo; } resp_t;

  grant_t      grant_q[$];
  resp_t       exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;

  // Requester index: 0 = store, 1 = load, 2 = fetch (also the fixed priority order).
  bit          act[3];
  logic [31:0] raddr[3];
  logic [31:0] rdata[3];
  int          wt[3];
  int          gap[3];
  bit          busy = 1'b0;
  bit          gen_en = 1'b0;
  bit          mem_silent = 1'b0;
  bit          tmo_sticky = 1'b0;
  int          force_s = -1;
  int          force_d = -1;
  logic [31:0] last_if = '0;
  logic [31:0] last_ld = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Waiting requesters that have waited SL cycles pre-empt everyone else.
  function automatic int winner();
    for (int r = 0; r < 3; r++) if (act[r] && wt[r] >= SL) return r;
    for (int r = 0; r < 3; r++) if (act[r]) return r;
    return -1;
  endfunction

  task automatic drive_reqs();
    st_req_valid = act[0]; st_req_addr = raddr[0]; st_req_data = rdata[0];
    ld_req_valid = act[1]; ld_req_addr = raddr[1];
    if_req_valid = act[2]; if_req_addr = raddr[2];
  endtask

  task automatic step();
    int     w;
    int     exp_rdy;
    int     got;
    logic   any_resp;
    grant_t g;
    @(negedge clk);
    if (gen_en) begin
      for (int r = 0; r < 3; r++) begin
        if (!act[r]) begin
          if (gap[r] > 0) gap[r]--;
          else if ($urandom_range(0, 3) != 0) begin
            act[r]   = 1'b1;
            raddr[r] = 32'($urandom_range(0, 63)) << 2;
            rdata[r] = $urandom();
            wt[r]    = 0;
          end
        end
      end
    end
    drive_reqs();
    #1;
    any_resp = if_resp_valid | ld_resp_valid | st_resp_valid;
    w        = busy ? -1 : winner();
    exp_rdy  = (w >= 0) ? (1 << w) : 0;
    got      = int'({if_req_ready, ld_req_ready, st_req_ready});
    chk("req_ready", 64'(got), 64'(exp_rdy));
    for (int r = 0; r < 3; r++) begin
      if (act[r]) begin
        if (r == w) begin
          g.owner = r;
          g.addr  = raddr[r];
          g.wdata = (r == 0) ? rdata[r] : 32'h0;
          g.we    = (r == 0);
          grant_q.push_back(g);
          act[r]  = 1'b0;
          wt[r]   = 0;
          gap[r]  = $urandom_range(0, 2);
          busy    = 1'b1;
        end else begin
          wt[r]++;
        end
      end
    end
    if (any_resp) busy = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin act[r] = 1'b0; wt[r] = 0; gap[r] = 0; end
    drive_reqs();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    busy = 1'b0; tmo_sticky = 1'b0; last_if = '0; last_ld = '0;
    grant_q.delete(); exp_q.delete();
    #1;
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_req_we", 64'(mem_req_we), 64'd0);
    chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_mem_req_wdata", 64'(mem_req_wdata), 64'd0);
    chk("rst_resp_valids", 64'({if_resp_valid, ld_resp_valid, st_resp_valid}), 64'd0);
    chk("rst_req_readies", 64'({if_req_ready, ld_req_ready, st_req_ready}), 64'd0);
    chk("rst_if_resp_data", 64'(if_resp_data), 64'd0);
    chk("rst_ld_resp_data", 64'(ld_resp_data), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
  endtask

  // Memory model: random accept stall and response delay; delays of TO or more
  // cycles are predicted as timeouts and the late response is delivered as a stray.
  initial begin : mem_model
    grant_t      g;
    resp_t       e;
    int          s;
    int          d;
    logic [31:0] rd;
    logic [31:0] hold_wdata;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid) begin
        chk("mem_req_pending", 64'(grant_q.size() != 0), 64'd1);
        if (grant_q.size() != 0) begin
          g = grant_q.pop_front();
          chk("mem_req_we", 64'(mem_req_we), 64'(g.we));
          chk("mem_req_addr", 64'(mem_req_addr), 64'(g.addr));
          if (g.we) chk("mem_req_wdata", 64'(mem_req_wdata), 64'(g.wdata));
          hold_wdata = mem_req_wdata;
          s = (force_s >= 0) ? force_s : (($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 2)));
          for (int i = 0; i < s; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_addr", 64'(mem_req_addr), 64'(g.addr));
            chk("stall_wdata", 64'(mem_req_wdata), 64'(hold_wdata));
            chk("stall_we", 64'(mem_req_we), 64'(g.we));
          end
          mem_req_ready = 1'b1;
          rd = g.we ? 32'h0 : mem_rd(g.addr);
          if (g.we) ref_mem[g.addr] = g.wdata;
          @(negedge clk);
          mem_req_ready = 1'b0;
          chk("wait_req_valid_low", 64'(mem_req_valid), 64'd0);
          d = (force_d >= 0) ? force_d :
              (($urandom_range(0, 5) == 0) ? int'($urandom_range(TO, TO + 1)) : int'($urandom_range(0, TO - 1)));
          if (!mem_silent) begin
            if (d <= TO - 1) begin
              e.owner = g.owner; e.data = rd; e.tmo = tmo_sticky;
            end else begin
              tmo_sticky = 1'b1;
              e.owner = g.owner; e.data = 32'h0; e.tmo = 1'b1;
            end
            exp_q.push_back(e);
            repeat (d) @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_resp_data  = g.we ? 32'hFFFF_FFFF : rd;
            @(negedge clk);
            mem_resp_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin : resp_monitor
    resp_t      e;
    logic [2:0] rv;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        rv = {if_resp_valid, ld_resp_valid, st_resp_valid};
        if (rv != 3'b000) begin
          chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_owner", 64'(rv), 64'd1 << e.owner);
            chk("resp_timeout_err", 64'(timeout_err), 64'(e.tmo));
            if (e.owner == 2) begin chk("if_resp_data", 64'(if_resp_data), 64'(e.data)); last_if = e.data; end
            if (e.owner == 1) begin chk("ld_resp_data", 64'(ld_resp_data), 64'(e.data)); last_ld = e.data; end
          end
        end else begin
          chk("if_data_hold", 64'(if_resp_data), 64'(last_if));
          chk("ld_data_hold", 64'(ld_resp_data), 64'(last_ld));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog got=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    for (int r = 0; r < 3; r++) begin act[r] = 1'b0; raddr[r] = '0; rdata[r] = '0; wt[r] = 0; gap[r] = 0; end
    drive_reqs();
    do_reset(2);

    // single load with a two-cycle response delay
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    force_s = 0; force_d = 2;
    act[1] = 1'b1; raddr[1] = 32'h100;
    repeat (8) step();
    chk("single_load_data", 64'(ld_resp_data), 64'hDEAD_BEEF);

    // three-way contention; the load reads back the store
    force_d = 1;
    act[0] = 1'b1; raddr[0] = 32'h40; rdata[0] = 32'h1234_5678;
    act[1] = 1'b1; raddr[1] = 32'h40;
    act[2] = 1'b1; raddr[2] = 32'h80;
    repeat (24) step();
    chk("contention_ld_data", 64'(ld_resp_data), 64'h1234_5678);

    // response on the final WAIT cycle beats the timeout
    force_d = TO - 1;
    act[1] = 1'b1; raddr[1] = 32'h44;
    repeat (10) step();
    chk("simul_no_timeout", 64'(timeout_err), 64'd0);

    // timeouts with late stray responses landing in IDLE and in RESP
    force_d = TO + 1;
    act[1] = 1'b1; raddr[1] = 32'h48;
    repeat (12) step();
    chk("timeout_sticky", 64'(timeout_err), 64'd1);
    force_d = TO;
    act[2] = 1'b1; raddr[2] = 32'h4C;
    repeat (12) step();
    chk("timeout_if_data", 64'(if_resp_data), 64'd0);

    // randomised contention, back-pressure and timeouts
    force_s = -1; force_d = -1; gen_en = 1'b1;
    repeat (800) step();
    gen_en = 1'b0;
    n = 0;
    while ((busy || act[0] || act[1] || act[2] || exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_done", 64'(n < 300), 64'd1);
    repeat (8) step();

    // reset in the middle of WAIT drops the transaction
    force_s = 0; force_d = -1;
    act[1] = 1'b1; raddr[1] = 32'h50;
    mem_silent = 1'b1;
    repeat (4) step();
    chk("pre_reset_timeout_err", 64'(timeout_err), 64'd1);
    do_reset(1);
    mem_silent = 1'b0;
    repeat (6) step();
    force_d = 1;
    act[2] = 1'b1; raddr[2] = 32'h54;
    repeat (10) step();
    chk("post_reset_if_data", 64'(if_resp_data), 64'(mem_rd(32'h54)));
    chk("post_reset_timeout_err", 64'(timeout_err), 64'd0);
    chk("post_reset_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
